// File: rtl/sort_bank_sched_pkg.sv
// Shared types and width helpers for the banked sort-buffer scheduler.
// Bank state encodings are fixed so downstream debug taps can decode them.
package sort_bank_sched_pkg;

  typedef enum logic [1:0] {
    StFree    = 2'd0,
    StWriting = 2'd1,
    StFull    = 2'd2,
    StReading = 2'd3
  } bank_state_e;

  function automatic int unsigned alt_clogb2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) res = i + 1;
    end
    return res;
  endfunction

  function automatic int unsigned bank_width(input int unsigned banks);
    return (alt_clogb2(banks) > 1) ? alt_clogb2(banks) : 1;
  endfunction

  function automatic int unsigned addr_width(input int unsigned max_length);
    return alt_clogb2(max_length);
  endfunction

endpackage

// File: rtl/sort_bank_sched_if.sv
// Writer/reader handshake bundle between the scheduler and the input/output blocks.
// The master modport is the scheduler side; slave is the writer/reader side.
interface sort_bank_sched_if
  import sort_bank_sched_pkg::*;
#(
  parameter int unsigned BANKS      = 2,
  parameter int unsigned MAX_LENGTH = 256
);
  localparam int unsigned ADDR_WIDTH = addr_width(MAX_LENGTH);
  localparam int unsigned BANK_WIDTH = bank_width(BANKS);

  logic                  wr_alloc_req;
  logic                  wr_alloc_gnt;
  logic [BANK_WIDTH-1:0] wr_bank;
  logic                  wr_done;
  logic [ADDR_WIDTH-1:0] wr_len;
  logic                  rd_avail;
  logic [BANK_WIDTH-1:0] rd_bank;
  logic [ADDR_WIDTH-1:0] rd_len;
  logic                  rd_take;
  logic                  rd_done;
  logic [BANK_WIDTH:0]   fill_cnt;
  logic                  err_proto;

  modport master (
    input  wr_alloc_req, wr_done, wr_len, rd_take, rd_done,
    output wr_alloc_gnt, wr_bank, rd_avail, rd_bank, rd_len, fill_cnt, err_proto
  );

  modport slave (
    output wr_alloc_req, wr_done, wr_len, rd_take, rd_done,
    input  wr_alloc_gnt, wr_bank, rd_avail, rd_bank, rd_len, fill_cnt, err_proto
  );
endinterface

// File: rtl/sort_bank_slot.sv
// One buffer bank: lifecycle state plus the stored length-1 of its packet.
// Strobes are only honoured in the matching state; the top qualifies them per bank.
module sort_bank_slot
  import sort_bank_sched_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_grant,
  input  logic                  i_done,
  input  logic                  i_take,
  input  logic                  i_release,
  input  logic [ADDR_WIDTH-1:0] i_len,
  output bank_state_e           o_state,
  output logic [ADDR_WIDTH-1:0] o_len
);
  bank_state_e           r_state;
  logic [ADDR_WIDTH-1:0] r_len;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StFree;
      r_len   <= '0;
    end else begin
      unique case (r_state)
        StFree:    if (i_grant) r_state <= StWriting;
        StWriting: if (i_done) begin
          r_state <= StFull;
          r_len   <= i_len;
        end
        StFull:    if (i_take) r_state <= StReading;
        StReading: if (i_release) r_state <= StFree;
      endcase
    end
  end

  assign o_state = r_state;
  assign o_len   = r_len;
endmodule

// File: rtl/sort_bank_sched.sv
// Round-robin bank scheduler: grants free banks to the writer and presents filled
// banks to the reader in fill order, so capture of one packet overlaps readout of the last.
module sort_bank_sched
  import sort_bank_sched_pkg::*;
#(
  parameter int unsigned BANKS      = 2,
  parameter int unsigned MAX_LENGTH = 256
) (
  input  logic                    ctl_clock,
  input  logic                    ctl_reset_n,
  sort_bank_sched_if.master       bus
);
  localparam int unsigned ADDR_WIDTH = addr_width(MAX_LENGTH);
  localparam int unsigned BANK_WIDTH = bank_width(BANKS);

  bank_state_e           w_state [BANKS];
  logic [ADDR_WIDTH-1:0] w_len   [BANKS];

  logic [BANK_WIDTH-1:0] r_wr_ptr, r_rd_ptr, r_wr_bank, r_rd_bank;
  logic                  r_wr_open, r_wr_alloc_gnt, r_rd_avail, r_err_proto;
  logic [ADDR_WIDTH-1:0] r_rd_len;
  logic [BANK_WIDTH:0]   r_fill_cnt;

  logic w_grant, w_wr_done_ok, w_take_ok, w_rd_done_ok, w_err;

  function automatic logic [BANK_WIDTH-1:0] next_ptr(input logic [BANK_WIDTH-1:0] p);
    return (p == BANK_WIDTH'(BANKS - 1)) ? '0 : p + 1'b1;
  endfunction

  // wr_open gates the grant, so a wr_done in the same cycle as a request defers the grant.
  assign w_grant      = bus.wr_alloc_req && !r_wr_open && (w_state[r_wr_ptr] == StFree);
  assign w_wr_done_ok = bus.wr_done && r_wr_open;
  assign w_take_ok    = bus.rd_take && r_rd_avail;
  assign w_rd_done_ok = bus.rd_done && (w_state[r_rd_ptr] == StReading);
  assign w_err        = (bus.wr_done && !r_wr_open) || (bus.rd_take && !r_rd_avail) ||
                        (bus.rd_done && !w_rd_done_ok);

  for (genvar b = 0; b < BANKS; b++) begin : g_slot
    sort_bank_slot #(
      .ADDR_WIDTH(ADDR_WIDTH)
    ) u_slot (
      .i_clk     (ctl_clock),
      .i_rst_n   (ctl_reset_n),
      .i_grant   (w_grant && (r_wr_ptr == BANK_WIDTH'(b))),
      .i_done    (w_wr_done_ok && (r_wr_ptr == BANK_WIDTH'(b))),
      .i_take    (w_take_ok && (r_rd_ptr == BANK_WIDTH'(b))),
      .i_release (w_rd_done_ok && (r_rd_ptr == BANK_WIDTH'(b))),
      .i_len     (bus.wr_len),
      .o_state   (w_state[b]),
      .o_len     (w_len[b])
    );
  end

  always_ff @(posedge ctl_clock or negedge ctl_reset_n) begin
    if (!ctl_reset_n) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_wr_bank      <= '0;
      r_rd_bank      <= '0;
      r_wr_open      <= 1'b0;
      r_wr_alloc_gnt <= 1'b0;
      r_rd_avail     <= 1'b0;
      r_rd_len       <= '0;
      r_fill_cnt     <= '0;
      r_err_proto    <= 1'b0;
    end else begin
      r_wr_alloc_gnt <= w_grant;
      if (w_grant) begin
        r_wr_open <= 1'b1;
        r_wr_bank <= r_wr_ptr;
      end else if (w_wr_done_ok) begin
        r_wr_open <= 1'b0;
        r_wr_ptr  <= next_ptr(r_wr_ptr);
      end
      // A take this cycle must drop rd_avail at once, not one cycle later.
      r_rd_avail <= (w_state[r_rd_ptr] == StFull) && !w_take_ok;
      r_rd_bank  <= r_rd_ptr;
      r_rd_len   <= w_len[r_rd_ptr];
      if (w_rd_done_ok) r_rd_ptr <= next_ptr(r_rd_ptr);
      unique case ({w_wr_done_ok, w_rd_done_ok})
        2'b10:   r_fill_cnt <= r_fill_cnt + 1'b1;
        2'b01:   r_fill_cnt <= r_fill_cnt - 1'b1;
        default: r_fill_cnt <= r_fill_cnt;
      endcase
      if (w_err) r_err_proto <= 1'b1;
    end
  end

  assign bus.wr_alloc_gnt = r_wr_alloc_gnt;
  assign bus.wr_bank      = r_wr_bank;
  assign bus.rd_avail     = r_rd_avail;
  assign bus.rd_bank      = r_rd_bank;
  assign bus.rd_len       = r_rd_len;
  assign bus.fill_cnt     = r_fill_cnt;
  assign bus.err_proto    = r_err_proto;
endmodule

// File: tb/tb_sort_bank_sched.sv
// Self-checking bench for sort_bank_sched: a 2-bank instance for flow/corner cases and a
// 3-bank instance for round-robin wrap, driven from a vector table through a scoreboard.
module tb_sort_bank_sched;
  logic clk;
  logic rst_n;

  sort_bank_sched_if #(.BANKS(2), .MAX_LENGTH(256)) bus2 ();
  sort_bank_sched_if #(.BANKS(3), .MAX_LENGTH(256)) bus3 ();

  sort_bank_sched #(.BANKS(2), .MAX_LENGTH(256)) dut2 (
    .ctl_clock   (clk),
    .ctl_reset_n (rst_n),
    .bus         (bus2)
  );

  sort_bank_sched #(.BANKS(3), .MAX_LENGTH(256)) dut3 (
    .ctl_clock   (clk),
    .ctl_reset_n (rst_n),
    .bus         (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] len;
    logic [1:0] bank;
  } vec_t;

  int   n_checks;
  int   n_fail;
  vec_t vecs [7];
  vec_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus2.wr_alloc_req = 0; bus2.wr_done = 0; bus2.wr_len = '0;
    bus2.rd_take = 0; bus2.rd_done = 0;
    bus3.wr_alloc_req = 0; bus3.wr_done = 0; bus3.wr_len = '0;
    bus3.rd_take = 0; bus3.rd_done = 0;
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic wr_grant2();
    bus2.wr_alloc_req = 1;
    tick();
    bus2.wr_alloc_req = 0;
  endtask

  task automatic wr_done2(input logic [7:0] len);
    bus2.wr_len = len;
    bus2.wr_done = 1;
    tick();
    bus2.wr_done = 0;
  endtask

  task automatic pulse_take2();
    bus2.rd_take = 1;
    tick();
    bus2.rd_take = 0;
  endtask

  // Bank 0 READING with length 11, bank 1 WRITING.
  task automatic setup_rw2();
    do_reset();
    wr_grant2();
    wr_done2(8'd11);
    wr_grant2();
    check("setup_wr_bank1", 32'(bus2.wr_bank), 1);
    tick();
    pulse_take2();
  endtask

  initial begin
    logic [1:0] exp_banks [7] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0};
    logic       got;
    logic       seen_gnt;
    vec_t       popped;

    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 7; i++) begin
      vecs[i].len  = 8'(i * 37 + 5);
      vecs[i].bank = exp_banks[i];
    end

    // Reset values and basic flow
    do_reset();
    check("rst_gnt", 32'(bus2.wr_alloc_gnt), 0);
    check("rst_avail", 32'(bus2.rd_avail), 0);
    check("rst_err", 32'(bus2.err_proto), 0);
    check("rst_fill", 32'(bus2.fill_cnt), 0);
    check("rst_rd_len", 32'(bus2.rd_len), 0);
    wr_grant2();
    check("basic_gnt", 32'(bus2.wr_alloc_gnt), 1);
    check("basic_wr_bank", 32'(bus2.wr_bank), 0);
    tick();
    check("basic_gnt_pulse", 32'(bus2.wr_alloc_gnt), 0);
    wr_done2(8'd9);
    check("basic_avail_early", 32'(bus2.rd_avail), 0);
    tick();
    check("basic_avail", 32'(bus2.rd_avail), 1);
    check("basic_rd_bank", 32'(bus2.rd_bank), 0);
    check("basic_rd_len", 32'(bus2.rd_len), 9);
    check("basic_fill1", 32'(bus2.fill_cnt), 1);
    pulse_take2();
    check("basic_avail_drop", 32'(bus2.rd_avail), 0);
    bus2.rd_done = 1;
    tick();
    bus2.rd_done = 0;
    check("basic_fill0", 32'(bus2.fill_cnt), 0);
    check("basic_err", 32'(bus2.err_proto), 0);

    // Overlap: both banks occupied, third request stalls until bank 0 is released
    do_reset();
    wr_grant2();
    wr_done2(8'd4);
    wr_grant2();
    check("ovl_wr_bank1", 32'(bus2.wr_bank), 1);
    wr_done2(8'd200);
    bus2.wr_alloc_req = 1;
    seen_gnt = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (bus2.wr_alloc_gnt) seen_gnt = 1;
    end
    check("ovl_no_gnt_full", 32'(seen_gnt), 0);
    check("ovl_fill2", 32'(bus2.fill_cnt), 2);
    check("ovl_rd_len0", 32'(bus2.rd_len), 4);
    pulse_take2();
    check("ovl_no_gnt_reading", 32'(bus2.wr_alloc_gnt), 0);
    bus2.rd_done = 1;
    tick();
    bus2.rd_done = 0;
    check("ovl_gnt_not_bypassed", 32'(bus2.wr_alloc_gnt), 0);
    tick();
    bus2.wr_alloc_req = 0;
    check("ovl_gnt", 32'(bus2.wr_alloc_gnt), 1);
    check("ovl_gnt_bank0", 32'(bus2.wr_bank), 0);
    check("ovl_rd_bank1", 32'(bus2.rd_bank), 1);
    check("ovl_rd_len200", 32'(bus2.rd_len), 200);
    check("ovl_avail1", 32'(bus2.rd_avail), 1);
    check("ovl_fill1", 32'(bus2.fill_cnt), 1);

    // Same-cycle wr_done on bank 1 and rd_done on bank 0
    setup_rw2();
    check("same_fill_before", 32'(bus2.fill_cnt), 1);
    bus2.wr_len  = 8'd33;
    bus2.wr_done = 1;
    bus2.rd_done = 1;
    tick();
    bus2.wr_done = 0;
    bus2.rd_done = 0;
    check("same_fill_after", 32'(bus2.fill_cnt), 1);
    tick();
    check("same_avail", 32'(bus2.rd_avail), 1);
    check("same_rd_bank", 32'(bus2.rd_bank), 1);
    check("same_rd_len", 32'(bus2.rd_len), 33);
    check("same_err", 32'(bus2.err_proto), 0);

    // Asynchronous reset mid-operation
    setup_rw2();
    check("mid_pre_rd_len", 32'(bus2.rd_len), 11);
    #2;
    rst_n = 0;
    #1;
    check("mid_rst_wr_bank", 32'(bus2.wr_bank), 0);
    check("mid_rst_fill", 32'(bus2.fill_cnt), 0);
    check("mid_rst_rd_len", 32'(bus2.rd_len), 0);
    check("mid_rst_avail", 32'(bus2.rd_avail), 0);
    check("mid_rst_gnt", 32'(bus2.wr_alloc_gnt), 0);
    #3;
    rst_n = 1;
    tick();
    wr_grant2();
    check("mid_post_gnt", 32'(bus2.wr_alloc_gnt), 1);
    check("mid_post_bank", 32'(bus2.wr_bank), 0);

    // Protocol errors
    do_reset();
    pulse_take2();
    check("err_take", 32'(bus2.err_proto), 1);
    check("err_take_fill", 32'(bus2.fill_cnt), 0);
    check("err_take_avail", 32'(bus2.rd_avail), 0);
    wr_grant2();
    check("err_take_gnt_bank", 32'(bus2.wr_bank), 0);
    check("err_take_gnt", 32'(bus2.wr_alloc_gnt), 1);
    do_reset();
    check("err_cleared", 32'(bus2.err_proto), 0);
    wr_done2(8'd7);
    check("err_wrdone", 32'(bus2.err_proto), 1);
    tick();
    check("err_wrdone_fill", 32'(bus2.fill_cnt), 0);
    check("err_wrdone_avail", 32'(bus2.rd_avail), 0);
    do_reset();
    bus2.rd_done = 1;
    tick();
    bus2.rd_done = 0;
    check("err_rddone", 32'(bus2.err_proto), 1);

    // Round-robin wrap with three banks, table-driven through the scoreboard
    do_reset();
    for (int i = 0; i < 7; i++) begin
      bus3.wr_alloc_req = 1;
      got = 0;
      for (int k = 0; k < 8; k++) begin
        tick();
        if (bus3.wr_alloc_gnt) begin
          got = 1;
          break;
        end
      end
      bus3.wr_alloc_req = 0;
      check($sformatf("wrap_gnt_%0d", i), 32'(got), 1);
      check($sformatf("wrap_wr_bank_%0d", i), 32'(bus3.wr_bank), 32'(vecs[i].bank));
      sb.push_back(vecs[i]);
      bus3.wr_len  = vecs[i].len;
      bus3.wr_done = 1;
      tick();
      bus3.wr_done = 0;
      got = 0;
      for (int k = 0; k < 8; k++) begin
        tick();
        if (bus3.rd_avail) begin
          got = 1;
          break;
        end
      end
      check($sformatf("wrap_avail_%0d", i), 32'(got), 1);
      if (sb.size() > 0) begin
        popped = sb.pop_front();
        check($sformatf("wrap_rd_bank_%0d", i), 32'(bus3.rd_bank), 32'(popped.bank));
        check($sformatf("wrap_rd_len_%0d", i), 32'(bus3.rd_len), 32'(popped.len));
      end
      bus3.rd_take = 1;
      tick();
      bus3.rd_take = 0;
      bus3.rd_done = 1;
      tick();
      bus3.rd_done = 0;
    end
    check("wrap_fill_end", 32'(bus3.fill_cnt), 0);
    check("wrap_err_end", 32'(bus3.err_proto), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
